// File: rtl/exc_ctrl_if.sv
// Signal bundle between the MEM/WB pipeline, CP0 and the exception commit controller.
// The master side drives pipeline/CP0 state; the slave side is the controller.
interface exc_ctrl_if;
  logic [5:0]  stall;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delayslot;
  logic [31:0] mem_bad_vaddr;
  logic [8:0]  mem_exc;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic [37:0] wb_cp0_bus;
  logic [31:0] excepttype_o;
  logic [31:0] pc_o;
  logic [31:0] bad_vaddr_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport master (
    output stall, mem_valid, mem_pc, mem_in_delayslot, mem_bad_vaddr, mem_exc,
           status_i, cause_i, epc_i, wb_cp0_bus,
    input  excepttype_o, pc_o, bad_vaddr_o, is_in_delayslot_o, flush_o, new_pc_o
  );

  modport slave (
    input  stall, mem_valid, mem_pc, mem_in_delayslot, mem_bad_vaddr, mem_exc,
           status_i, cause_i, epc_i, wb_cp0_bus,
    output excepttype_o, pc_o, bad_vaddr_o, is_in_delayslot_o, flush_o, new_pc_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/ERET commit controller at the MEM->WB boundary: prioritises the MEM-stage
// exception flags against the registered interrupt state and issues a one-cycle commit.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic       clk,
  input  logic       rst,
  exc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_int_pend;
  logic        w_int_pend_next;
  logic [7:0]  r_code;
  logic [31:0] r_pc;
  logic [31:0] r_bad_vaddr;
  logic        r_in_delayslot;
  logic [31:0] r_new_pc;

  logic        w_has_exc;
  logic        w_is_eret;
  logic        w_take;
  logic [7:0]  w_code;
  logic [31:0] w_bad_vaddr;
  logic [31:0] w_epc;
  logic [31:0] w_new_pc;
  logic        w_unused;

  assign w_int_pend_next = bus.status_i[0] & ~bus.status_i[1]
                         & (|(bus.cause_i[15:8] & bus.status_i[15:8]));

  assign w_unused = ^{bus.stall[5:4], bus.stall[2:0], bus.status_i[31:16],
                      bus.status_i[7:2], bus.cause_i[31:16], bus.cause_i[7:0]};

  // EPC written by the instruction now in WB must win over the stale CP0 copy.
  assign w_epc = (bus.wb_cp0_bus[37] && (bus.wb_cp0_bus[36:32] == 5'd14))
               ? bus.wb_cp0_bus[31:0] : bus.epc_i;

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_has_exc    = 1'b1;
    w_is_eret    = 1'b0;
    w_code       = 8'h00;
    w_bad_vaddr  = 32'd0;

    if (r_int_pend) begin
      w_code = 8'h01;
    end else if (bus.mem_exc[0]) begin
      w_code      = 8'h04;
      w_bad_vaddr = bus.mem_pc;
    end else if (bus.mem_exc[1]) begin
      w_code = 8'h0a;
    end else if (bus.mem_exc[2]) begin
      w_code = 8'h08;
    end else if (bus.mem_exc[3]) begin
      w_code = 8'h09;
    end else if (bus.mem_exc[4]) begin
      w_code = 8'h0c;
    end else if (bus.mem_exc[5]) begin
      w_code = 8'h0d;
    end else if (bus.mem_exc[6]) begin
      w_code      = 8'h04;
      w_bad_vaddr = bus.mem_bad_vaddr;
    end else if (bus.mem_exc[7]) begin
      w_code      = 8'h05;
      w_bad_vaddr = bus.mem_bad_vaddr;
    end else if (bus.mem_exc[8]) begin
      w_code    = 8'h0e;
      w_is_eret = 1'b1;
    end else begin
      w_has_exc = 1'b0;
    end

    w_new_pc = w_is_eret ? w_epc : EXC_VECTOR;

    case (r_state)
      S_IDLE: begin
        if (bus.mem_valid && !bus.stall[3] && w_has_exc) begin
          w_take       = 1'b1;
          w_state_next = S_COMMIT;
        end
      end
      S_COMMIT: w_state_next = S_DRAIN;
      S_DRAIN:  w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_pend     <= 1'b0;
      r_code         <= 8'h00;
      r_pc           <= 32'd0;
      r_bad_vaddr    <= 32'd0;
      r_in_delayslot <= 1'b0;
      r_new_pc       <= 32'd0;
    end else begin
      r_int_pend <= w_int_pend_next;
      if (w_take) begin
        r_code         <= w_code;
        r_pc           <= bus.mem_pc;
        r_bad_vaddr    <= w_bad_vaddr;
        r_in_delayslot <= bus.mem_in_delayslot;
        r_new_pc       <= w_new_pc;
      end
    end
  end

  // Code and flush are gated by state so an async reset kills a commit in flight.
  assign bus.excepttype_o      = (r_state == S_COMMIT) ? {24'd0, r_code} : 32'd0;
  assign bus.flush_o           = (r_state == S_COMMIT);
  assign bus.pc_o              = r_pc;
  assign bus.bad_vaddr_o       = r_bad_vaddr;
  assign bus.is_in_delayslot_o = r_in_delayslot;
  assign bus.new_pc_o          = r_new_pc;

endmodule
